// File: rtl/adc_pkg.sv
// adc_pkg: shared definitions for the multichannel serial ADC capture block.
//   state_t   : FSM encodings (INICIO / CAPTURAR / LISTO)
//   clog2     : ceiling log2 for counter widths
//   LEAD_BITS : leading (discarded) bits per frame for the default geometry
package adc_pkg;

  typedef enum logic [1:0] {
    INICIO   = 2'b00,
    CAPTURAR = 2'b01,
    LISTO    = 2'b10
  } state_t;

  localparam int unsigned DEF_FRAME_BITS = 16;
  localparam int unsigned DEF_DATA_BITS  = 12;
  localparam int unsigned LEAD_BITS      = DEF_FRAME_BITS - DEF_DATA_BITS;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/adc_canal_shift.sv
// adc_canal_shift: one serial data line captured MSB-first into a
// FRAME_BITS-wide shift register.
//   i_clk      : sampling clock (rising edge)
//   i_rst_n    : synchronous active-low reset, clears the register
//   i_shift_en : shift in i_din this cycle
//   i_din      : serial data bit
//   o_q        : captured frame, most recent bit in o_q[0]
module adc_canal_shift #(
  parameter int unsigned FRAME_BITS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_shift_en,
  input  logic                  i_din,
  output logic [FRAME_BITS-1:0] o_q
);

  logic [FRAME_BITS-1:0] r_sh;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sh <= '0;
    end else if (i_shift_en) begin
      r_sh <= {r_sh[FRAME_BITS-2:0], i_din};
    end
  end

  assign o_q = r_sh;

endmodule

// File: rtl/adc_serial_multicanal.sv
// adc_serial_multicanal: captures NUM_CH serial ADC lines under one shared
// active-low chip select, single-shot or continuous, with a guaranteed
// CS-high quiet time and a one-entry valid/ready output register.
// Ports:
//   Clock_Muestreo : sampling / ADC serial clock (rising edge)
//   reset          : synchronous active-low reset
//   start          : request one frame (sampled in INICIO only)
//   continuous     : back-to-back frames while high
//   data_ADC       : serial data, bit c = channel c
//   CS             : ADC chip select, active low, registered
//   busy           : FSM not idle
//   done           : one-cycle pulse on each new load of Dato
//   dato_valid     : output register holds an unconsumed sample
//   dato_ready     : consumer accepts when dato_valid && dato_ready
//   Dato           : channel c at [c*DATA_BITS +: DATA_BITS]
//   data_basura    : leading bits of each channel, same packing
//   overrun        : one-cycle pulse when a finished frame is dropped
//   frame_err      : nonzero leading bits (only with ADC_LEADZERO_CHECK_EN)
// Build option: define ADC_LEADZERO_CHECK_EN to enable the leading-zero check.
module adc_serial_multicanal
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned FRAME_BITS   = 16,
  parameter int unsigned DATA_BITS    = 12,
  parameter int unsigned QUIET_CYCLES = 2
) (
  input  logic                                   Clock_Muestreo,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   continuous,
  input  logic [NUM_CH-1:0]                      data_ADC,
  output logic                                   CS,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   dato_valid,
  input  logic                                   dato_ready,
  output logic [NUM_CH*DATA_BITS-1:0]            Dato,
  output logic [NUM_CH*(FRAME_BITS-DATA_BITS)-1:0] data_basura,
  output logic                                   overrun,
  output logic                                   frame_err
);

  localparam int unsigned LB    = FRAME_BITS - DATA_BITS;
  localparam int unsigned CNT_W = clog2(FRAME_BITS);
  localparam int unsigned QW    = clog2(QUIET_CYCLES) + 1;
  localparam logic [QW-1:0]    Q_SAT    = QW'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [QW-1:0]            r_quiet;
  logic                     r_cs;
  logic                     r_valid;
  logic                     r_done;
  logic                     r_ovr;
  logic [NUM_CH*DATA_BITS-1:0] r_dato;
  logic [NUM_CH*LB-1:0]     r_bas;

  logic                     w_shift_en;
  logic                     w_load;
  logic [FRAME_BITS-1:0]    w_sh [NUM_CH];
  logic [NUM_CH*DATA_BITS-1:0] w_dato_nx;
  logic [NUM_CH*LB-1:0]     w_bas_nx;

  assign w_shift_en = (r_state == CAPTURAR);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_canal
    adc_canal_shift #(
      .FRAME_BITS(FRAME_BITS)
    ) u_shift (
      .i_clk      (Clock_Muestreo),
      .i_rst_n    (reset),
      .i_shift_en (w_shift_en),
      .i_din      (data_ADC[c]),
      .o_q        (w_sh[c])
    );
  end

  always_comb begin
    w_dato_nx = '0;
    w_bas_nx  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_dato_nx[c*DATA_BITS +: DATA_BITS] = w_sh[c][DATA_BITS-1:0];
      w_bas_nx[c*LB +: LB]                = w_sh[c][FRAME_BITS-1:DATA_BITS];
    end
  end

  // A finished frame is accepted if the output slot is free or is being
  // consumed in this same cycle.
  assign w_load = (r_state == LISTO) && (!r_valid || dato_ready);

`ifdef ADC_LEADZERO_CHECK_EN
  logic r_ferr;
  logic w_lead_err;
  assign w_lead_err = |w_bas_nx;
`endif

  always_ff @(posedge Clock_Muestreo) begin
    if (!reset) begin
      r_state <= INICIO;
      r_cs    <= 1'b1;
      r_cnt   <= '0;
      r_quiet <= Q_SAT;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
      r_dato  <= '0;
      r_bas   <= '0;
`ifdef ADC_LEADZERO_CHECK_EN
      r_ferr  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
`ifdef ADC_LEADZERO_CHECK_EN
      r_ferr <= 1'b0;
`endif
      // Plain consume; a load in LISTO below overrides this.
      if (r_valid && dato_ready) r_valid <= 1'b0;

      case (r_state)
        INICIO: begin
          r_cs <= 1'b1;
          if (r_quiet != Q_SAT) r_quiet <= r_quiet + 1'b1;
          if ((start || continuous) && (r_quiet >= Q_SAT)) begin
            r_cs    <= 1'b0;
            r_cnt   <= '0;
            r_state <= CAPTURAR;
          end
        end
        CAPTURAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_cs    <= 1'b1;
            r_state <= LISTO;
          end
        end
        LISTO: begin
          // LISTO is itself the first CS-high cycle of the quiet gap.
          r_quiet <= QW'(1);
          r_state <= INICIO;
          if (w_load) begin
            r_dato  <= w_dato_nx;
            r_bas   <= w_bas_nx;
            r_valid <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_ovr <= 1'b1;
          end
`ifdef ADC_LEADZERO_CHECK_EN
          r_ferr <= w_lead_err;
`endif
        end
        default: begin
          r_state <= INICIO;
          r_cs    <= 1'b1;
        end
      endcase
    end
  end

  assign CS          = r_cs;
  assign busy        = (r_state != INICIO);
  assign done        = r_done;
  assign overrun     = r_ovr;
  assign dato_valid  = r_valid;
  assign Dato        = r_dato;
  assign data_basura = r_bas;
`ifdef ADC_LEADZERO_CHECK_EN
  assign frame_err   = r_ferr;
`else
  assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_adc_serial_multicanal.sv
module tb_adc_serial_multicanal;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned FB     = 16;
  localparam int unsigned DB     = 12;
  localparam int unsigned QC     = 2;
  localparam int unsigned LB     = FB - DB;
`ifdef ADC_LEADZERO_CHECK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic                   continuous;
  logic [NUM_CH-1:0]      data_ADC;
  logic                   CS;
  logic                   busy;
  logic                   done;
  logic                   dato_valid;
  logic                   dato_ready;
  logic [NUM_CH*DB-1:0]   Dato;
  logic [NUM_CH*LB-1:0]   data_basura;
  logic                   overrun;
  logic                   frame_err;

  always #5 clk = ~clk;

  adc_serial_multicanal #(
    .NUM_CH(NUM_CH), .FRAME_BITS(FB), .DATA_BITS(DB), .QUIET_CYCLES(QC)
  ) dut (
    .Clock_Muestreo(clk), .reset(reset), .start(start), .continuous(continuous),
    .data_ADC(data_ADC), .CS(CS), .busy(busy), .done(done),
    .dato_valid(dato_valid), .dato_ready(dato_ready), .Dato(Dato),
    .data_basura(data_basura), .overrun(overrun), .frame_err(frame_err)
  );

  typedef struct {
    logic [NUM_CH*DB-1:0] dato;
    logic [NUM_CH*LB-1:0] bas;
    bit                   drop;
    bit                   ferr;
  } exp_t;

  exp_t                   exp_q[$];
  logic [NUM_CH*FB-1:0]   frm_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_CH*FB-1:0] frame2(input logic [15:0] c0, input logic [15:0] c1);
    return {c1, c0};
  endfunction

  function automatic exp_t mk(input logic [23:0] d, input logic [7:0] b, input bit drop, input bit ferr);
    exp_t e;
    e.dato = d; e.bas = b; e.drop = drop; e.ferr = ferr;
    return e;
  endfunction

  // ADC model: presents the next frame MSB-first while CS is low.
  int drv_idx = 0;
  logic [NUM_CH*FB-1:0] cur_frm = '0;
  always @(negedge clk) begin
    if (CS === 1'b0) begin
      if (drv_idx == 0) cur_frm = (frm_q.size() > 0) ? frm_q.pop_front() : '0;
      for (int c = 0; c < NUM_CH; c++) data_ADC[c] = cur_frm[c*FB + FB - 1 - drv_idx];
      drv_idx++;
    end else begin
      drv_idx = 0;
    end
  end

  // Monitor: CS framing plus scoreboard on done/overrun.
  bit prev_cs = 1'b1;
  bit had_low = 1'b0;
  bit skip_cs = 1'b0;
  int lo_cnt = 0, hi_cnt = 0, last_gap = -1;
  int cs_falls = 0, n_done = 0, n_ovr = 0;
  always @(negedge clk) begin
    exp_t e;
    if (CS === 1'b0) begin
      if (prev_cs) begin
        cs_falls++;
        if (had_low) last_gap = hi_cnt;
      end
      lo_cnt++;
      hi_cnt = 0;
    end else begin
      if (!prev_cs) begin
        if (!skip_cs) chk("cs_low_len", 64'(lo_cnt), 64'(FB));
        lo_cnt  = 0;
        had_low = 1'b1;
      end
      hi_cnt++;
    end
    prev_cs = (CS !== 1'b0);

    if (done === 1'b1 || overrun === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {done, overrun}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        chk("out_kind", {done, overrun}, e.drop ? 2'b01 : 2'b10);
        chk("dato", Dato, e.dato);
        chk("basura", data_basura, e.bas);
        chk("frame_err", frame_err, e.ferr);
        chk("valid_out", dato_valid, 1'b1);
      end
      if (done === 1'b1) n_done++;
      if (overrun === 1'b1) n_ovr++;
    end else if (frame_err !== 1'b0) begin
      chk("frame_err_stray", frame_err, 1'b0);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_falls(input int target, input int budget);
    int k = 0;
    while (cs_falls < target && k < budget) begin tick(); k++; end
    chk("wait_cs_fall", cs_falls >= target, 1'b1);
  endtask

  task automatic wait_dones(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin tick(); k++; end
    chk("wait_done", n_done >= target, 1'b1);
  endtask

  task automatic wait_ovr(input int target, input int budget);
    int k = 0;
    while (n_ovr < target && k < budget) begin tick(); k++; end
    chk("wait_overrun", n_ovr >= target, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, d0, o0, first;
    reset = 1'b0; start = 1'b0; continuous = 1'b0; dato_ready = 1'b1; data_ADC = '0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (4) tick();

    // Reset held two cycles while idle
    reset = 1'b0;
    repeat (2) tick();
    chk("rst_cs", CS, 1'b1);
    chk("rst_valid", dato_valid, 1'b0);
    chk("rst_dato", Dato, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    reset = 1'b1;
    repeat (3) tick();

    // Single shot, latency to done
    exp_q.push_back(mk(24'h123ABC, 8'h00, 1'b0, 1'b0));
    frm_q.push_back(frame2(16'h0ABC, 16'h0123));
    start = 1'b1;
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (done === 1'b1 && first == 0) first = k;
    end
    chk("done_latency", 64'(first), 64'd18);
    chk("valid_consumed", dato_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);

    // Continuous with the consumer stalled: second frame overruns
    dato_ready = 1'b0;
    base = cs_falls;
    o0 = n_ovr;
    exp_q.push_back(mk(24'h123ABC, 8'h00, 1'b0, 1'b0));
    exp_q.push_back(mk(24'h123ABC, 8'h00, 1'b1, 1'b0));
    frm_q.push_back(frame2(16'h0ABC, 16'h0123));
    frm_q.push_back(frame2(16'h0FFF, 16'h0FFF));
    continuous = 1'b1;
    wait_falls(base + 2, 80);
    continuous = 1'b0;
    chk("quiet_gap_cont", 64'(last_gap), 64'(QC));
    wait_ovr(o0 + 1, 60);
    tick();
    chk("ovr_valid_held", dato_valid, 1'b1);
    chk("ovr_dato_held", Dato, 24'h123ABC);
    repeat (30) tick();
    chk("no_extra_frame_cont", 64'(cs_falls), 64'(base + 2));
    dato_ready = 1'b1;
    tick();
    chk("valid_cleared", dato_valid, 1'b0);
    repeat (3) tick();

    // Reset at bit 7 of a frame: frame abandoned
    d0 = n_done;
    base = cs_falls;
    frm_q.push_back(frame2(16'h0111, 16'h0222));
    pulse_start();
    wait_falls(base + 1, 20);
    repeat (7) tick();
    skip_cs = 1'b1;
    reset = 1'b0;
    tick();
    chk("abort_cs", CS, 1'b1);
    chk("abort_busy", busy, 1'b0);
    reset = 1'b1;
    repeat (25) tick();
    chk("abort_no_done", 64'(n_done), 64'(d0));
    chk("abort_no_valid", dato_valid, 1'b0);
    skip_cs = 1'b0;
    exp_q.push_back(mk(24'h789456, 8'h00, 1'b0, 1'b0));
    frm_q.push_back(frame2(16'h0456, 16'h0789));
    pulse_start();
    wait_dones(d0 + 1, 60);
    repeat (3) tick();

    // start held through capture: one frame per INICIO visit
    d0 = n_done;
    base = cs_falls;
    exp_q.push_back(mk(24'h654321, 8'h00, 1'b0, 1'b0));
    exp_q.push_back(mk(24'h555AAA, 8'h00, 1'b0, 1'b0));
    frm_q.push_back(frame2(16'h0321, 16'h0654));
    frm_q.push_back(frame2(16'h0AAA, 16'h0555));
    start = 1'b1;
    wait_falls(base + 2, 80);
    start = 1'b0;
    chk("quiet_gap_start", 64'(last_gap), 64'(QC));
    wait_dones(d0 + 2, 60);
    repeat (30) tick();
    chk("start_held_frames", 64'(cs_falls), 64'(base + 2));

    // start pulse while busy is ignored
    d0 = n_done;
    base = cs_falls;
    exp_q.push_back(mk(24'h0F0F0F, 8'h00, 1'b0, 1'b0));
    frm_q.push_back(frame2(16'h0F0F, 16'h00F0));
    pulse_start();
    wait_falls(base + 1, 20);
    repeat (5) tick();
    pulse_start();
    repeat (40) tick();
    chk("busy_start_frames", 64'(cs_falls), 64'(base + 1));
    chk("busy_start_dones", 64'(n_done), 64'(d0 + 1));

    // Nonzero leading nibble on channel 1
    d0 = n_done;
    exp_q.push_back(mk(24'h123ABC, 8'h50, 1'b0, LZ_EN));
    frm_q.push_back(frame2(16'h0ABC, 16'h5123));
    pulse_start();
    wait_dones(d0 + 1, 60);
    repeat (5) tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_serial_multicanal.md
Name: adc_serial_multicanal

Overview:
- Parametrised successor of the single-channel serial ADC capture block.
- Captures NUM_CH serial ADC data lines in parallel under one shared active-low chip select. Lines are sampled MSB-first on Clock_Muestreo, which is also the ADC serial clock.
- Supports single-shot and continuous conversion, with a guaranteed minimum CS-high quiet time between frames.
- Presents samples through a one-entry valid/ready output register with overrun reporting. Sits between the ADC pins and the sample-processing logic.

Parameters:
- NUM_CH, 2, number of serial data lines sharing CS (1..8).
- FRAME_BITS, 16, Clock_Muestreo cycles with CS low per frame (DATA_BITS+1..32).
- DATA_BITS, 12, conversion result width; the last DATA_BITS bits of each frame.
- QUIET_CYCLES, 2, minimum CS-high cycles between frames (>=2).

Ports:
- Clock_Muestreo  in  1  sampling/serial clock; all logic on rising edge.
- reset  in  1  reset, synchronous and active-low.
- start  in  1  request one frame; sampled only in INICIO.
- continuous  in  1  while high, back-to-back frames without start.
- data_ADC  in  NUM_CH  serial data; bit c = channel c.
- CS  out  1  ADC chip select, active low, registered.
- busy  out  1  high when state != INICIO.
- done  out  1  one-cycle pulse, coincident with each new load of Dato.
- dato_valid  out  1  Dato/data_basura hold an unconsumed sample.
- dato_ready  in  1  consumer accepts the sample when dato_valid && dato_ready.
- Dato  out  NUM_CH*DATA_BITS  channel c at [c*DATA_BITS +: DATA_BITS].
- data_basura  out  NUM_CH*(FRAME_BITS-DATA_BITS)  leading bits per channel, same packing.
- overrun  out  1  one-cycle pulse when a finished frame is dropped.
- frame_err  out  1  see Optional Feature.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=INICIO, CS=1, bit counter=0, quiet counter saturated.
  - Shift registers=0, Dato=0, data_basura=0.
  - dato_valid=0, done=0, overrun=0, frame_err=0.
  - Any frame in flight is abandoned; no partial sample is ever presented.
- INICIO (CS=1):
  - If (start||continuous) && quiet_cnt>=QUIET_CYCLES-1: CS_N=0, counter=0, go to CAPTURAR.
  - start is ignored in every other state; it is level-sampled, not queued.
- CAPTURAR (CS=0):
  - Each cycle, every channel shifts sh_c <= {sh_c[FRAME_BITS-2:0], data_ADC[c]}, and the counter increments.
  - On counter==FRAME_BITS-1: the last bit shifts in, CS_N=1, go to LISTO.
  - CS is low for exactly FRAME_BITS cycles.
- LISTO (CS=1, one cycle), with quiet_cnt set to 1:
  - If !dato_valid || dato_ready: Dato <= low DATA_BITS of every sh_c, data_basura <= upper bits, dato_valid<=1, done<=1.
  - Else: outputs keep the old sample, overrun<=1, new frame discarded.
  - Always go to INICIO.
- quiet_cnt increments, saturating, each INICIO cycle. CS-high gap between continuous frames = exactly QUIET_CYCLES.
- Latency: start seen at cycle 0 -> CS low cycles 1..FRAME_BITS -> LISTO at FRAME_BITS+1 -> dato_valid/done at FRAME_BITS+2.
- Output handshake:
  - dato_valid && dato_ready with no load that cycle -> dato_valid<=0.
  - Consume and load in the same cycle -> dato_valid stays 1 with the new data.
  - Dato is stable while dato_valid && !dato_ready.
- continuous dropping mid-frame: the current frame completes normally; no further frame starts.
- Unused state encoding -> INICIO with CS_N=1.

Optional Feature:
- Macro ADC_LEADZERO_CHECK_EN.
- When defined: in LISTO, if any channel's leading bits are nonzero, frame_err<=1 for one cycle, coincident with done (or with overrun if dropped). The sample is still delivered.
- When undefined: frame_err is tied to 0 and the check logic is absent.

Decomposition:
- Package adc_pkg holds:
  - State encodings INICIO=2'b00, CAPTURAR=2'b01, LISTO=2'b10.
  - A clog2 function for counter widths.
  - A derived LEAD_BITS=FRAME_BITS-DATA_BITS constant.
- One sub-module, adc_canal_shift: a per-channel FRAME_BITS shift register with shift enable, instantiated NUM_CH times via generate.
- The FSM, counters and output register stay in the top level.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-idle -> CS=1, dato_valid=0, Dato=0, busy=0.
- Single shot (NUM_CH=2, dato_ready=1): start one cycle, ch0 frame 0x0ABC, ch1 frame 0x0123 -> CS low exactly 16 cycles, done at cycle 18, Dato=24'h123ABC, data_basura=8'h00, overrun=0.
- Continuous, dato_ready=0 after the first sample -> CS high exactly 2 cycles between frames; second LISTO pulses overrun, Dato stays 24'h123ABC, dato_valid stays 1.
- Reset mid-frame at bit 7 -> CS=1 next cycle, no done or dato_valid. A later start yields a full 16-cycle frame with the correct data.
- start held high through CAPTURAR with continuous=0 -> exactly one frame per INICIO visit, quiet gap respected; start pulse during busy alone -> no extra frame.
- ADC_LEADZERO_CHECK_EN defined, ch1 leading nibble 0x5 -> frame_err pulses with done, Dato still updated. Macro undefined -> frame_err stays 0.
